// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/stall controller.
// Register-field widths, controller states and the load-use compare.
package cpu_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    // $0 is hard-wired zero, so a load targeting it never creates a dependency.
    function automatic logic load_use_hazard(
        input logic             memread,
        input logic [REG_W-1:0] ex_rt,
        input logic [REG_W-1:0] id_rs,
        input logic [REG_W-1:0] id_rt
    );
        return memread && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard/stall controller (slave).
// Carries hazard sources, the data-memory handshake and the pipeline control outputs.
interface hazard_stall_ctrl_if
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic             ID_EX_memread_i;
    logic [REG_W-1:0] ID_EX_RT_i;
    logic [REG_W-1:0] IF_ID_RS_i;
    logic [REG_W-1:0] IF_ID_RT_i;
    logic             branch_taken_i;
    logic             EX_MEM_memaccess_i;
    logic             dmem_ack_i;
    logic             dmem_req_o;
    logic             PC_write_o;
    logic             IF_ID_write_o;
    logic             IF_ID_flush_o;
    logic             ID_EX_bubble_o;
    logic             pipe_stall_o;
    logic             error_o;
    logic [CNT_W-1:0] stall_cycles_o;

    modport master (
        output ID_EX_memread_i, ID_EX_RT_i, IF_ID_RS_i, IF_ID_RT_i,
               branch_taken_i, EX_MEM_memaccess_i, dmem_ack_i,
        input  dmem_req_o, PC_write_o, IF_ID_write_o, IF_ID_flush_o,
               ID_EX_bubble_o, pipe_stall_o, error_o, stall_cycles_o
    );

    modport slave (
        input  ID_EX_memread_i, ID_EX_RT_i, IF_ID_RS_i, IF_ID_RT_i,
               branch_taken_i, EX_MEM_memaccess_i, dmem_ack_i,
        output dmem_req_o, PC_write_o, IF_ID_write_o, IF_ID_flush_o,
               ID_EX_bubble_o, pipe_stall_o, error_o, stall_cycles_o
    );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Synchronous active-low clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_clr_n,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;

    // Count enabled cycles, holding once the maximum is reached.
    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_cnt <= {WIDTH{1'b0}};
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall, taken-branch flush and data-memory wait control for the 5-stage pipe.
// Memory waits freeze the whole pipe; a stuck memory latches a sticky error.
module hazard_stall_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input logic                clk_i,
    input logic                rst_i,
    hazard_stall_ctrl_if.slave bus
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_next;
    logic [WAIT_W-1:0] w_wait_inc;
    logic             w_req_raw;
    logic             w_req;
    logic             w_mem_stall;
    logic             w_error;
    logic             w_load_use;
    logic             w_cnt_en;
    logic [CNT_W-1:0] w_stall_cnt;

    assign w_error     = (r_state == ERROR);
    assign w_req_raw   = (r_state == MEM_WAIT) || ((r_state == RUN) && bus.EX_MEM_memaccess_i);
    // Holding reset drops an outstanding request immediately.
    assign w_req       = w_req_raw && rst_i;
    assign w_mem_stall = w_req && !bus.dmem_ack_i;
    assign w_load_use  = load_use_hazard(bus.ID_EX_memread_i, bus.ID_EX_RT_i,
                                         bus.IF_ID_RS_i, bus.IF_ID_RT_i);
    assign w_wait_inc  = r_wait_cnt + WAIT_ONE;

    // Next state: a miss in RUN counts as the first unacknowledged cycle.
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait_cnt;
        case (r_state)
            RUN: begin
                if (w_req_raw && !bus.dmem_ack_i) begin
                    w_state_next = (WAIT_LIMIT <= WAIT_ONE) ? ERROR : MEM_WAIT;
                    w_wait_next  = WAIT_ONE;
                end else begin
                    w_wait_next  = {WAIT_W{1'b0}};
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ack_i) begin
                    w_state_next = RUN;
                    w_wait_next  = {WAIT_W{1'b0}};
                end else if (w_wait_inc >= WAIT_LIMIT) begin
                    w_state_next = ERROR;
                    w_wait_next  = w_wait_inc;
                end else begin
                    w_wait_next  = w_wait_inc;
                end
            end
            ERROR: begin
                w_state_next = ERROR;
            end
            default: begin
                w_state_next = RUN;
                w_wait_next  = {WAIT_W{1'b0}};
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state    <= RUN;
            r_wait_cnt <= {WAIT_W{1'b0}};
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
        end
    end

    // Priority mux: reset, memory stall/error, load-use bubble, branch flush, normal flow.
    always_comb begin
        bus.PC_write_o     = 1'b1;
        bus.IF_ID_write_o  = 1'b1;
        bus.IF_ID_flush_o  = 1'b0;
        bus.ID_EX_bubble_o = 1'b0;
        bus.pipe_stall_o   = 1'b0;
        if (!rst_i || w_mem_stall || w_error) begin
            bus.PC_write_o    = 1'b0;
            bus.IF_ID_write_o = 1'b0;
            bus.pipe_stall_o  = 1'b1;
        end else if (w_load_use) begin
            bus.PC_write_o     = 1'b0;
            bus.IF_ID_write_o  = 1'b0;
            bus.ID_EX_bubble_o = 1'b1;
        end else if (bus.branch_taken_i) begin
            bus.IF_ID_flush_o = 1'b1;
        end else begin
            bus.IF_ID_flush_o = 1'b0;
        end
    end

    assign w_cnt_en = w_mem_stall || w_load_use || w_error;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .i_clk   (clk_i),
        .i_clr_n (rst_i),
        .i_en    (w_cnt_en),
        .o_cnt   (w_stall_cnt)
    );

    assign bus.dmem_req_o     = w_req;
    assign bus.error_o        = w_error;
    assign bus.stall_cycles_o = w_stall_cnt;

endmodule
